// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer: FSM states, CSR word offsets
// and the fp_mac register addresses it drives.
package mac_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_W,
    WAIT_W,
    FETCH_X,
    WAIT_X,
    WR_A,
    WR_B,
    WR_C,
    RD_RES,
    RD_CAP,
    DONE
  } state_t;

  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_STATUS = 3'd1;
  localparam logic [2:0] CSR_W_BASE = 3'd2;
  localparam logic [2:0] CSR_X_BASE = 3'd3;
  localparam logic [2:0] CSR_LEN    = 3'd4;
  localparam logic [2:0] CSR_BIAS   = 3'd5;
  localparam logic [2:0] CSR_RESULT = 3'd6;

  localparam logic [2:0] MAC_ADDR_A = 3'd0;
  localparam logic [2:0] MAC_ADDR_B = 3'd1;
  localparam logic [2:0] MAC_ADDR_C = 3'd2;

endpackage

// File: rtl/mac_seq_regs.sv
// CSR slave for the MAC sequencer: configuration registers, start pulse,
// sticky done flag, result capture and the level interrupt.
module mac_seq_regs
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       s_address,
  input  logic [31:0]      s_writedata,
  input  logic             s_write,
  input  logic             s_read,
  output logic [31:0]      s_readdata,
  input  logic             busy,
  input  logic             done_set,
  input  logic [31:0]      result_in,
  output logic             start_pulse,
  output logic             irq,
  output logic [31:0]      w_base,
  output logic [31:0]      x_base,
  output logic [31:0]      bias,
  output logic [LEN_W-1:0] len
);

  logic        done_q;
  logic        irq_en_q;
  logic [31:0] result_q;
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'd0;
    case (s_address)
      CSR_CTRL:   rd_mux = {30'd0, irq_en_q, 1'b0};
      CSR_STATUS: rd_mux = {30'd0, done_q, busy};
      CSR_W_BASE: rd_mux = w_base;
      CSR_X_BASE: rd_mux = x_base;
      CSR_LEN:    rd_mux = 32'(len);
      CSR_BIAS:   rd_mux = bias;
      CSR_RESULT: rd_mux = result_q;
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_pulse <= 1'b0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      result_q    <= 32'd0;
      w_base      <= 32'd0;
      x_base      <= 32'd0;
      bias        <= 32'd0;
      len         <= '0;
      s_readdata  <= 32'd0;
    end else begin
      start_pulse <= 1'b0;
      if (s_write) begin
        case (s_address)
          CSR_CTRL: begin
            irq_en_q <= s_writedata[1];
            if (s_writedata[0] && !busy) begin
              start_pulse <= 1'b1;
              done_q      <= 1'b0;
            end
          end
          CSR_STATUS: if (s_writedata[1]) done_q <= 1'b0;
          CSR_W_BASE: if (!busy) w_base <= s_writedata;
          CSR_X_BASE: if (!busy) x_base <= s_writedata;
          CSR_LEN:    if (!busy) len <= s_writedata[LEN_W-1:0];
          CSR_BIAS:   if (!busy) bias <= s_writedata;
          default: ;
        endcase
      end
      // completion wins over a same-cycle write-1-clear
      if (done_set) begin
        done_q   <= 1'b1;
        result_q <= result_in;
      end
      if (s_read) s_readdata <= rd_mux;
    end
  end

  assign irq = done_q & irq_en_q;

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: fetches w[i], x[i] over the read master and folds them
// into acc through an external fp_mac (acc = acc + w*x) for LEN elements.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH_W | request w[i], hold until accepted
//   WAIT_W  | wait for w[i] data
//   FETCH_X | request x[i], hold until accepted
//   WAIT_X  | wait for x[i] data
//   WR_A    | write w to fp_mac
//   WR_B    | write x to fp_mac
//   WR_C    | write acc to fp_mac
//   RD_RES  | read fp_mac result
//   RD_CAP  | capture result into acc, advance i
//   DONE    | publish RESULT, set done
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  input  logic        s_write,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [2:0]  mac_address,
  output logic [31:0] mac_writedata,
  output logic        mac_write,
  output logic        mac_read,
  input  logic [31:0] mac_readdata,
  output logic        irq
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  i_q, i_next, len;
  logic [31:0]       acc_q, w_q, x_q;
  logic [31:0]       w_base, x_base, bias, offset;
  logic              start_pulse, done_set, busy;

  // a start accepted last cycle already counts as busy so a back-to-back start is refused
  assign busy   = (state_q != IDLE) || start_pulse;
  assign i_next = i_q + LEN_W'(1);
  assign offset = 32'(i_q) * 32'(STRIDE);

  mac_seq_regs #(.LEN_W(LEN_W)) u_regs (
    .clk         (clk),
    .reset       (reset),
    .s_address   (s_address),
    .s_writedata (s_writedata),
    .s_write     (s_write),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .busy        (busy),
    .done_set    (done_set),
    .result_in   (acc_q),
    .start_pulse (start_pulse),
    .irq         (irq),
    .w_base      (w_base),
    .x_base      (x_base),
    .bias        (bias),
    .len         (len)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    m_read        = 1'b0;
    m_address     = 32'd0;
    mac_address   = MAC_ADDR_A;
    mac_writedata = 32'd0;
    mac_write     = 1'b0;
    mac_read      = 1'b0;
    done_set      = 1'b0;
    case (state_q)
      IDLE:    if (start_pulse) state_d = (len == '0) ? DONE : FETCH_W;
      FETCH_W: begin
        m_read    = 1'b1;
        m_address = w_base + offset;
        if (!m_waitrequest) state_d = WAIT_W;
      end
      WAIT_W:  if (m_readdatavalid) state_d = FETCH_X;
      FETCH_X: begin
        m_read    = 1'b1;
        m_address = x_base + offset;
        if (!m_waitrequest) state_d = WAIT_X;
      end
      WAIT_X:  if (m_readdatavalid) state_d = WR_A;
      WR_A: begin
        mac_write     = 1'b1;
        mac_address   = MAC_ADDR_A;
        mac_writedata = w_q;
        state_d       = WR_B;
      end
      WR_B: begin
        mac_write     = 1'b1;
        mac_address   = MAC_ADDR_B;
        mac_writedata = x_q;
        state_d       = WR_C;
      end
      WR_C: begin
        mac_write     = 1'b1;
        mac_address   = MAC_ADDR_C;
        mac_writedata = acc_q;
        state_d       = RD_RES;
      end
      RD_RES: begin
        mac_read = 1'b1;
        state_d  = RD_CAP;
      end
      RD_CAP:  state_d = (i_next == len) ? DONE : FETCH_W;
      DONE: begin
        done_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q   <= '0;
      acc_q <= 32'd0;
      w_q   <= 32'd0;
      x_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (start_pulse) begin
          acc_q <= bias;
          i_q   <= '0;
        end
        WAIT_W: if (m_readdatavalid) w_q <= m_readdata;
        WAIT_X: if (m_readdatavalid) x_q <= m_readdata;
        RD_CAP: begin
          acc_q <= mac_readdata;
          i_q   <= i_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a stallable memory slave and a
// behavioural fp_mac (result = c + a*b) built around the DUT.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  s_address;
  logic [31:0] s_writedata;
  logic        s_write, s_read;
  logic [31:0] s_readdata;
  logic [31:0] m_address;
  logic        m_read, m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic [2:0]  mac_address;
  logic [31:0] mac_writedata;
  logic        mac_write, mac_read;
  logic [31:0] mac_readdata;
  logic        irq;

  always #5 clk = ~clk;

  mac_sequencer #(.LEN_W(16), .STRIDE(4)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_writedata(s_writedata), .s_write(s_write),
    .s_read(s_read), .s_readdata(s_readdata),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .mac_address(mac_address), .mac_writedata(mac_writedata),
    .mac_write(mac_write), .mac_read(mac_read), .mac_readdata(mac_readdata),
    .irq(irq)
  );

  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000, F7 = 32'h40E00000;

  int tests = 0;
  int fails = 0;

  function automatic real sp2r(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // memory slave: stall_n waitrequest cycles per read, data one cycle after acceptance
  logic [31:0] mem [0:63];
  int          stall_n = 0;
  int          stall_cnt;
  logic        mr_s, acc_s;
  logic [31:0] addr_s;

  assign m_waitrequest = m_read && (stall_cnt < stall_n);

  always @(negedge clk) begin
    mr_s   <= m_read;
    acc_s  <= m_read && !m_waitrequest;
    addr_s <= m_address;
  end

  always @(posedge clk) begin
    if (reset) begin
      stall_cnt       <= 0;
      m_readdatavalid <= 1'b0;
      m_readdata      <= 32'd0;
    end else begin
      m_readdatavalid <= acc_s;
      if (acc_s) m_readdata <= mem[addr_s[7:2]];
      if (acc_s)     stall_cnt <= 0;
      else if (mr_s) stall_cnt <= stall_cnt + 1;
    end
  end

  // fp_mac model
  logic [31:0] ma, mb, mc, mdata_s;
  logic [2:0]  maddr_s;
  logic        mw_s, mrd_s;

  always @(negedge clk) begin
    mw_s    <= mac_write;
    mrd_s   <= mac_read;
    maddr_s <= mac_address;
    mdata_s <= mac_writedata;
  end

  always @(posedge clk) begin
    if (reset) begin
      ma <= 32'd0; mb <= 32'd0; mc <= 32'd0; mac_readdata <= 32'd0;
    end else begin
      if (mw_s) begin
        if (maddr_s == 3'd0) ma <= mdata_s;
        if (maddr_s == 3'd1) mb <= mdata_s;
        if (maddr_s == 3'd2) mc <= mdata_s;
      end
      if (mrd_s) mac_readdata <= r2sp(sp2r(mc) + sp2r(ma) * sp2r(mb));
    end
  end

  // activity monitor
  int          mread_cyc = 0, macw_cyc = 0, macr_cyc = 0, both_cyc = 0, stall_err = 0;
  int          addr_n = 0;
  logic [31:0] addr_log [0:255];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  always @(negedge clk) begin
    if (m_read)              mread_cyc <= mread_cyc + 1;
    if (mac_write)           macw_cyc  <= macw_cyc + 1;
    if (mac_read)            macr_cyc  <= macr_cyc + 1;
    if (mac_write && mac_read) both_cyc <= both_cyc + 1;
    if (m_read && !m_waitrequest && addr_n < 256) begin
      addr_log[addr_n] <= m_address;
      addr_n           <= addr_n + 1;
    end
    if (prev_stall && m_read && m_address != prev_addr) stall_err <= stall_err + 1;
    prev_stall <= m_read && m_waitrequest;
    prev_addr  <= m_address;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    @(posedge clk); #1;
    s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic wait_irq(input int start_n, input int limit, output int n);
    n = start_n;
    while (irq !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic config_run(input logic [31:0] wb, input logic [31:0] xb,
                            input logic [31:0] ln, input logic [31:0] bs);
    csr_write(3'd2, wb);
    csr_write(3'd3, xb);
    csr_write(3'd4, ln);
    csr_write(3'd5, bs);
  endtask

  initial begin
    logic [31:0] rd;
    int n, b, mr0, mw0, mrd0, se0, irq_seen;

    reset = 1'b1; s_address = 3'd0; s_writedata = 32'd0; s_write = 1'b0; s_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_m_read", {31'd0, m_read}, 32'd0);
    check("rst_mac_write", {31'd0, mac_write}, 32'd0);
    csr_read(3'd1, rd); check("rst_status", rd, 32'd0);
    csr_read(3'd6, rd); check("rst_result", rd, 32'd0);
    csr_read(3'd7, rd); check("unmapped_read", rd, 32'd0);

    // LEN=1: 1.0 + 2.0*3.0
    mem[0] = F2; mem[16] = F3;
    config_run(32'h0, 32'h40, 32'd1, F1);
    b = addr_n; mr0 = mread_cyc; mw0 = macw_cyc; mrd0 = macr_cyc;
    csr_write(3'd0, 32'h3);
    wait_irq(0, 200, n);
    check("len1_latency", n, 11);
    csr_read(3'd6, rd); check("len1_result", rd, F7);
    csr_read(3'd1, rd); check("len1_status", rd, 32'h2);
    check("len1_m_read_cyc", mread_cyc - mr0, 2);
    check("len1_mac_write_cyc", macw_cyc - mw0, 3);
    check("len1_mac_read_cyc", macr_cyc - mrd0, 1);
    check("len1_addr_w", addr_log[b], 32'h0);
    check("len1_addr_x", addr_log[b+1], 32'h40);
    csr_write(3'd1, 32'h2);
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // LEN=3 of ones, plus start and LEN writes while busy
    for (int k = 0; k < 3; k++) begin mem[32+k] = F1; mem[48+k] = F1; end
    config_run(32'h80, 32'hC0, 32'd3, 32'd0);
    b = addr_n; mr0 = mread_cyc;
    csr_write(3'd0, 32'h3);
    csr_write(3'd4, 32'd5);
    csr_write(3'd0, 32'h3);
    wait_irq(2, 400, n);
    check("len3_latency", n, 29);
    csr_read(3'd6, rd); check("len3_result", rd, F3);
    csr_read(3'd4, rd); check("busy_len_write_ignored", rd, 32'd3);
    check("len3_m_read_cyc", mread_cyc - mr0, 6);
    check("len3_addr_w0", addr_log[b], 32'h80);
    check("len3_addr_w1", addr_log[b+2], 32'h84);
    check("len3_addr_w2", addr_log[b+4], 32'h88);
    check("len3_addr_x2", addr_log[b+5], 32'hC8);
    check("len3_irq_high", {31'd0, irq}, 32'd1);
    csr_write(3'd1, 32'h2);
    check("w1c_irq2", {31'd0, irq}, 32'd0);
    csr_read(3'd1, rd); check("w1c_status", rd, 32'd0);

    // LEN=0: straight to DONE
    config_run(32'h0, 32'h40, 32'd0, F1);
    mr0 = mread_cyc; mw0 = macw_cyc; mrd0 = macr_cyc;
    csr_write(3'd0, 32'h3);
    wait_irq(0, 100, n);
    check("len0_latency", n, 2);
    csr_read(3'd6, rd); check("len0_result", rd, F1);
    check("len0_m_read_cyc", mread_cyc - mr0, 0);
    check("len0_mac_cyc", (macw_cyc - mw0) + (macr_cyc - mrd0), 0);
    csr_write(3'd1, 32'h2);

    // 3 wait states on every read
    stall_n = 3;
    config_run(32'h80, 32'hC0, 32'd3, 32'd0);
    mr0 = mread_cyc; se0 = stall_err;
    csr_write(3'd0, 32'h3);
    wait_irq(0, 400, n);
    check("stall_latency", n, 47);
    csr_read(3'd6, rd); check("stall_result", rd, F3);
    check("stall_m_read_cyc", mread_cyc - mr0, 24);
    check("stall_addr_stable", stall_err - se0, 0);
    check("no_mac_rw_overlap", both_cyc, 0);
    stall_n = 0;
    csr_write(3'd1, 32'h2);

    // address wrap across 2^32
    mem[63] = F2; mem[0] = F1; mem[16] = F1; mem[17] = F1;
    config_run(32'hFFFFFFFC, 32'h40, 32'd2, F1);
    b = addr_n;
    csr_write(3'd0, 32'h3);
    wait_irq(0, 200, n);
    check("wrap_latency", n, 20);
    csr_read(3'd6, rd); check("wrap_result", rd, F4);
    check("wrap_addr_w0", addr_log[b], 32'hFFFFFFFC);
    check("wrap_addr_w1", addr_log[b+2], 32'h0);
    csr_write(3'd1, 32'h2);

    // irq gated by irq_en
    mem[0] = F2; mem[16] = F3;
    config_run(32'h0, 32'h40, 32'd1, F1);
    csr_write(3'd0, 32'h1);
    irq_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (irq) irq_seen++;
    end
    check("irq_masked", irq_seen, 0);
    csr_read(3'd1, rd); check("masked_status_done", rd, 32'h2);
    csr_read(3'd6, rd); check("masked_result", rd, F7);
    csr_write(3'd0, 32'h2);
    check("irq_enable_late", {31'd0, irq}, 32'd1);
    csr_write(3'd1, 32'h2);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);

    // reset while in WR_B
    csr_write(3'd0, 32'h3);
    repeat (6) @(posedge clk);
    #1;
    check("wr_b_mac_write", {31'd0, mac_write}, 32'd1);
    check("wr_b_mac_addr", {29'd0, mac_address}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_mac_write", {31'd0, mac_write}, 32'd0);
    check("rst_mid_m_read", {31'd0, m_read}, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    mw0 = macw_cyc;
    csr_read(3'd1, rd); check("rst_mid_status", rd, 32'd0);
    csr_read(3'd2, rd); check("rst_mid_w_base", rd, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_mac_write", macw_cyc - mw0, 0);
    config_run(32'h0, 32'h40, 32'd1, F1);
    csr_write(3'd0, 32'h3);
    wait_irq(0, 200, n);
    check("post_rst_latency", n, 11);
    csr_read(3'd6, rd); check("post_rst_result", rd, F7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
